// File: rtl/stopwatch_core_param.sv
// MM:SS stopwatch with run/adjust-up/adjust-down modes, pause toggle and a
// 4-digit multiplexed 7-segment driver. Optional blink: STOPWATCH_BLINK_EN.
module stopwatch_core_param #(
   parameter int TICK_DIV = 100_000_000,
   parameter int ADJ_DIV  = 50_000_000,
   parameter int SCAN_DIV = 100_000,
   parameter int MIN_MOD  = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pause,
   input  logic       sel,
   input  logic [1:0] adj,
   output logic [7:0] seven_segment,
   output logic [3:0] anode
);

   localparam int TW = $clog2(TICK_DIV);
   localparam int AW = $clog2(ADJ_DIV);
   localparam int SW = $clog2(SCAN_DIV);

   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [AW-1:0] ADJ_LAST  = AW'(ADJ_DIV - 1);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
   localparam logic [6:0]    MIN_LAST  = 7'(MIN_MOD - 1);

   typedef enum logic [1:0] {
      MODE_RUN = 2'd0,
      MODE_UP  = 2'd1,
      MODE_DN  = 2'd2
   } mode_e;

   logic [5:0]    sec_q, sec_d;
   logic [6:0]    min_q, min_d;
   logic          paused_q, paused_d;
   logic          pause_q, pause_d;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic [AW-1:0] adj_cnt_q, adj_cnt_d;
   logic [SW-1:0] scan_cnt_q, scan_cnt_d;
   logic [1:0]    scan_idx_q, scan_idx_d;
   mode_e         mode_q, mode_d;
   logic [7:0]    seg_q, seg_d;
   logic [3:0]    anode_q, anode_d;

   logic          mode_chg;
   logic          tick;
   logic          astep;
   logic [3:0]    digit;
   logic [3:0]    anode_base;

`ifdef STOPWATCH_BLINK_EN
   logic [AW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_q, blink_d;
   logic          blink_hide;
`endif

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   always_comb begin
      mode_d = MODE_RUN;
      case (adj)
         2'b01:   mode_d = MODE_UP;
         2'b10:   mode_d = MODE_DN;
         default: mode_d = MODE_RUN;
      endcase
   end

   assign mode_chg = (mode_d != mode_q);

   always_comb begin
      pause_d  = pause;
      paused_d = paused_q ^ (pause & ~pause_q);
   end

   // A mode change restarts both periods so the first step is a full period out.
   always_comb begin
      tick_cnt_d = tick_cnt_q;
      adj_cnt_d  = adj_cnt_q;
      tick       = 1'b0;
      astep      = 1'b0;
      if (mode_chg) begin
         tick_cnt_d = '0;
         adj_cnt_d  = '0;
      end else if (!paused_q) begin
         if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            tick       = 1'b1;
         end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
         end
         if (adj_cnt_q == ADJ_LAST) begin
            adj_cnt_d = '0;
            astep     = 1'b1;
         end else begin
            adj_cnt_d = adj_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      sec_d = sec_q;
      min_d = min_q;
      if (mode_q == MODE_RUN && tick) begin
         if (sec_q == 6'd59) begin
            sec_d = '0;
            min_d = (min_q == MIN_LAST) ? '0 : min_q + 7'd1;
         end else begin
            sec_d = sec_q + 6'd1;
         end
      end else if (mode_q == MODE_UP && astep) begin
         if (sel) begin
            sec_d = (sec_q == 6'd59) ? '0 : sec_q + 6'd1;
         end else begin
            min_d = (min_q == MIN_LAST) ? '0 : min_q + 7'd1;
         end
      end else if (mode_q == MODE_DN && astep) begin
         if (sel) begin
            sec_d = (sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1;
         end else begin
            min_d = (min_q == 7'd0) ? MIN_LAST : min_q - 7'd1;
         end
      end
   end

   always_comb begin
      scan_cnt_d = scan_cnt_q + 1'b1;
      scan_idx_d = scan_idx_q;
      if (scan_cnt_q == SCAN_LAST) begin
         scan_cnt_d = '0;
         scan_idx_d = scan_idx_q + 2'd1;
      end
   end

`ifdef STOPWATCH_BLINK_EN
   // Blink phase runs on its own counter so it keeps going while paused.
   always_comb begin
      blink_cnt_d = blink_cnt_q;
      blink_d     = blink_q;
      if (mode_chg || mode_q == MODE_RUN) begin
         blink_cnt_d = '0;
         blink_d     = 1'b0;
      end else if (blink_cnt_q == ADJ_LAST) begin
         blink_cnt_d = '0;
         blink_d     = ~blink_q;
      end else begin
         blink_cnt_d = blink_cnt_q + 1'b1;
      end
   end

   assign blink_hide = blink_q && (mode_q != MODE_RUN) &&
                       (sel ? !scan_idx_q[1] : scan_idx_q[1]);
`endif

   always_comb begin
      digit = 4'd0;
      case (scan_idx_q)
         2'd0:    digit = 4'(sec_q % 6'd10);
         2'd1:    digit = 4'(sec_q / 6'd10);
         2'd2:    digit = 4'(min_q % 7'd10);
         default: digit = 4'(min_q / 7'd10);
      endcase
   end

   always_comb begin
      anode_base = ~(4'b0001 << scan_idx_q);
      seg_d      = {(scan_idx_q != 2'd2), seg_code(digit)};
`ifdef STOPWATCH_BLINK_EN
      anode_d    = blink_hide ? 4'hF : anode_base;
`else
      anode_d    = anode_base;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sec_q      <= '0;
         min_q      <= '0;
         paused_q   <= 1'b0;
         pause_q    <= 1'b0;
         tick_cnt_q <= '0;
         adj_cnt_q  <= '0;
         scan_cnt_q <= '0;
         scan_idx_q <= '0;
         mode_q     <= MODE_RUN;
         seg_q      <= 8'hFF;
         anode_q    <= 4'hF;
`ifdef STOPWATCH_BLINK_EN
         blink_cnt_q <= '0;
         blink_q     <= 1'b0;
`endif
      end else begin
         sec_q      <= sec_d;
         min_q      <= min_d;
         paused_q   <= paused_d;
         pause_q    <= pause_d;
         tick_cnt_q <= tick_cnt_d;
         adj_cnt_q  <= adj_cnt_d;
         scan_cnt_q <= scan_cnt_d;
         scan_idx_q <= scan_idx_d;
         mode_q     <= mode_d;
         seg_q      <= seg_d;
         anode_q    <= anode_d;
`ifdef STOPWATCH_BLINK_EN
         blink_cnt_q <= blink_cnt_d;
         blink_q     <= blink_d;
`endif
      end
   end

   assign seven_segment = seg_q;
   assign anode         = anode_q;

endmodule

// File: tb/tb_stopwatch_core_param.sv
// Bench for stopwatch_core_param: per-cycle scoreboard against a behavioural
// model plus a table of MM:SS checkpoints read back from the scanned display.
module tb_stopwatch_core_param;

   localparam int TICK_DIV = 4;
   localparam int ADJ_DIV  = 2;
   localparam int SCAN_DIV = 2;
   localparam int MIN_MOD  = 60;

   logic       clk = 1'b0;
   logic       rst;
   logic       pause;
   logic       sel;
   logic [1:0] adj;
   logic [7:0] seven_segment;
   logic [3:0] anode;

   stopwatch_core_param #(
      .TICK_DIV(TICK_DIV),
      .ADJ_DIV (ADJ_DIV),
      .SCAN_DIV(SCAN_DIV),
      .MIN_MOD (MIN_MOD)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pause        (pause),
      .sel          (sel),
      .adj          (adj),
      .seven_segment(seven_segment),
      .anode        (anode)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] adj;
      logic       sel;
      int         n;
      int         hold;
      int         exp_min;
      int         exp_sec;
   } rec_t;

   typedef struct {
      logic [7:0] seg;
      logic [3:0] an;
   } out_t;

   logic [7:0] seg_tbl [10];
   rec_t       tbl [12];
   out_t       sb_q [$];

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] last_seg;
   logic [3:0] last_an;

   int m_sec, m_min, m_tick, m_adj, m_scan, m_idx, m_mode;
   bit m_paused, m_pause_q;
`ifdef STOPWATCH_BLINK_EN
   int m_bcnt;
   bit m_blink;
`endif

   task automatic model_eval();
      out_t e;
      int   mode_in;
      int   dig;
      bit   chg, tk, st;
      mode_in = (adj == 2'b01) ? 1 : (adj == 2'b10) ? 2 : 0;
      if (rst) begin
         e.seg = 8'hFF;
         e.an  = 4'hF;
         sb_q.push_back(e);
         m_sec = 0; m_min = 0; m_tick = 0; m_adj = 0;
         m_scan = 0; m_idx = 0; m_mode = 0;
         m_paused = 0; m_pause_q = 0;
`ifdef STOPWATCH_BLINK_EN
         m_bcnt = 0; m_blink = 0;
`endif
         return;
      end
      case (m_idx)
         0:       dig = m_sec % 10;
         1:       dig = m_sec / 10;
         2:       dig = m_min % 10;
         default: dig = m_min / 10;
      endcase
      e.seg = seg_tbl[dig];
      if (m_idx == 2) e.seg[7] = 1'b0;
      e.an = 4'hF;
      e.an[m_idx] = 1'b0;
`ifdef STOPWATCH_BLINK_EN
      if (m_blink && m_mode != 0 &&
          ((sel && m_idx < 2) || (!sel && m_idx >= 2)))
         e.an = 4'hF;
`endif
      sb_q.push_back(e);
      chg = (mode_in != m_mode);
      tk = 0;
      st = 0;
      if (chg) begin
         m_tick = 0;
         m_adj  = 0;
      end else if (!m_paused) begin
         if (m_tick == TICK_DIV - 1) begin m_tick = 0; tk = 1; end
         else m_tick++;
         if (m_adj == ADJ_DIV - 1) begin m_adj = 0; st = 1; end
         else m_adj++;
      end
      if (m_mode == 0 && tk) begin
         m_sec++;
         if (m_sec == 60) begin
            m_sec = 0;
            m_min = (m_min + 1) % MIN_MOD;
         end
      end else if (m_mode == 1 && st) begin
         if (sel) m_sec = (m_sec + 1) % 60;
         else     m_min = (m_min + 1) % MIN_MOD;
      end else if (m_mode == 2 && st) begin
         if (sel) m_sec = (m_sec + 59) % 60;
         else     m_min = (m_min + MIN_MOD - 1) % MIN_MOD;
      end
`ifdef STOPWATCH_BLINK_EN
      if (chg || m_mode == 0) begin
         m_bcnt  = 0;
         m_blink = 0;
      end else if (m_bcnt == ADJ_DIV - 1) begin
         m_bcnt  = 0;
         m_blink = !m_blink;
      end else begin
         m_bcnt++;
      end
`endif
      if (pause && !m_pause_q) m_paused = !m_paused;
      m_pause_q = pause;
      if (m_scan == SCAN_DIV - 1) begin
         m_scan = 0;
         m_idx  = (m_idx + 1) % 4;
      end else begin
         m_scan++;
      end
      m_mode = mode_in;
   endtask

   task automatic step();
      out_t e;
      model_eval();
      @(posedge clk);
      @(negedge clk);
      last_seg = seven_segment;
      last_an  = anode;
      n_vec++;
      if (sb_q.size() == 0) begin
         n_err++;
         $display("FAIL sb_empty t=%0t", $time);
      end else begin
         e = sb_q.pop_front();
         if (seven_segment !== e.seg || anode !== e.an) begin
            n_err++;
            $display("FAIL cycle t=%0t seg=%h an=%b required seg=%h an=%b",
                     $time, seven_segment, anode, e.seg, e.an);
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h required=%0h", name, got, exp);
      end
   endtask

   function automatic int decode(input logic [7:0] s);
      logic [7:0] v;
      v = s | 8'h80;
      for (int j = 0; j < 10; j++)
         if (v == seg_tbl[j]) return j;
      return -100;
   endfunction

   // Freeze (pause held high), read all four digits, then unpause.
   task automatic readout(input int idx, input int hold,
                          input int exp_min, input int exp_sec);
      logic [7:0] seen [4];
      int got_min, got_sec;
      for (int k = 0; k < 4; k++) seen[k] = 8'h00;
      adj   = 2'b00;
      pause = 1'b1;
      for (int i = 0; i < hold; i++) begin
         step();
         case (last_an)
            4'b1110: seen[0] = last_seg;
            4'b1101: seen[1] = last_seg;
            4'b1011: seen[2] = last_seg;
            4'b0111: seen[3] = last_seg;
            default: ;
         endcase
      end
      got_min = decode(seen[3]) * 10 + decode(seen[2]);
      got_sec = decode(seen[1]) * 10 + decode(seen[0]);
      n_vec++;
      if (got_min != exp_min || got_sec != exp_sec) begin
         n_err++;
         $display("FAIL time_rec%0d got=%0d:%0d required=%0d:%0d",
                  idx, got_min, got_sec, exp_min, exp_sec);
      end
      pause = 1'b0;
      step();
      pause = 1'b1;
      step();
      pause = 1'b0;
   endtask

   task automatic run_rec(input int idx, input rec_t r);
      adj = r.adj;
      sel = r.sel;
      for (int i = 1; i <= r.n; i++) begin
         pause = (i == r.n);
         step();
      end
      readout(idx, r.hold, r.exp_min, r.exp_sec);
   endtask

   initial begin
      int   n_blank, n_lo, n_hi;
      rec_t rr;
      seg_tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                  8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
      //          adj    sel   n   hold min sec
      tbl[0]  = '{2'b00, 1'b0, 39, 12, 0,  10};
      tbl[1]  = '{2'b10, 1'b0, 3,  12, 59, 10};
      tbl[2]  = '{2'b10, 1'b1, 25, 12, 59, 58};
      tbl[3]  = '{2'b00, 1'b0, 8,  12, 0,  0};
      tbl[4]  = '{2'b10, 1'b1, 3,  12, 0,  59};
      tbl[5]  = '{2'b00, 1'b0, 4,  12, 1,  0};
      tbl[6]  = '{2'b10, 1'b0, 3,  12, 0,  0};
      tbl[7]  = '{2'b10, 1'b1, 5,  12, 0,  58};
      tbl[8]  = '{2'b01, 1'b1, 7,  12, 0,  1};
      tbl[9]  = '{2'b10, 1'b0, 3,  12, 59, 1};
      tbl[10] = '{2'b01, 1'b0, 3,  12, 0,  1};
      tbl[11] = '{2'b00, 1'b0, 4,  40, 0,  2};

      rst   = 1'b1;
      pause = 1'b0;
      sel   = 1'b0;
      adj   = 2'b00;
      step();
      step();
      chk("reset_seg", {24'd0, seven_segment}, 32'hFF);
      chk("reset_anode", {28'd0, anode}, 32'hF);
      rst = 1'b0;
      step();
      chk("first_digit_seg", {24'd0, seven_segment}, 32'hC0);
      chk("first_digit_anode", {28'd0, anode}, 32'hE);

      for (int r = 0; r < 12; r++) run_rec(r, tbl[r]);

      rr = '{2'b00, 1'b0, 4, 12, 0, 3};
      run_rec(12, rr);

      adj   = 2'b10;
      sel   = 1'b0;
      pause = 1'b1;
      step();
      pause = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      chk("midrst_seg", {24'd0, seven_segment}, 32'hFF);
      chk("midrst_anode", {28'd0, anode}, 32'hF);
      rst = 1'b0;
      adj = 2'b00;
      step();
      chk("midrst_next_seg", {24'd0, seven_segment}, 32'hC0);
      chk("midrst_next_anode", {28'd0, anode}, 32'hE);
      rr = '{2'b00, 1'b0, 3, 12, 0, 1};
      run_rec(13, rr);

      adj     = 2'b01;
      sel     = 1'b0;
      pause   = 1'b0;
      n_blank = 0;
      n_lo    = 0;
      n_hi    = 0;
      for (int i = 0; i < 24; i++) begin
         step();
         if (last_an == 4'hF) n_blank++;
         if (last_an == 4'b1110 || last_an == 4'b1101) n_lo++;
         if (last_an == 4'b1011 || last_an == 4'b0111) n_hi++;
      end
      chk("blink_lo_scanned", {31'd0, n_lo > 0}, 32'd1);
      chk("blink_hi_scanned", {31'd0, n_hi > 0}, 32'd1);
`ifdef STOPWATCH_BLINK_EN
      chk("blink_suppressed", {31'd0, n_blank > 0}, 32'd1);
`else
      chk("blink_suppressed", n_blank, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/stopwatch_core_param.md
Name: stopwatch_core_param

Overview:
- Parametrised next-generation stopwatch: MM:SS counter with run, adjust-up and adjust-down modes, and a pause toggle.
- Drives a 4-digit multiplexed 7-segment display.
- Sits between the board-level debounced button/switch inputs and the display pins.
- Tick and scan rates and the minutes modulus are parameters, so simulation can use tiny dividers.

Parameters:
- TICK_DIV, 100_000_000, clk cycles per 1 Hz run tick (min 2)
- ADJ_DIV, 50_000_000, clk cycles per adjust step (2 Hz at 100 MHz; min 2)
- SCAN_DIV, 100_000, clk cycles per display digit slot (min 2)
- MIN_MOD, 60, minutes modulus, range 2..100; minutes count 0..MIN_MOD-1

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- pause  in  1  debounced level; each rising edge toggles the paused state
- sel  in  1  adjust field select: 0 = minutes, 1 = seconds
- adj  in  2  mode: 00 run, 01 adjust up, 10 adjust down, 11 treated as 00
- seven_segment  out  8  active-low segments; bit0=a … bit6=g, bit7=dp
- anode  out  4  active-low digit enables; bit3 = minutes tens … bit0 = seconds ones

Behaviour:
- Single clock domain. Reset is synchronous, active-high, sampled on clk rising edge.
- Reset state:
  - sec=0, min=0, paused=0.
  - All dividers = 0, scan index = 0, pause edge register = 0.
  - anode=4'b1111, seven_segment=8'hFF.
- Outputs are registered. First digit is driven on the cycle after rst deasserts.
- Pause edge detect: pause_q registers pause. A rise (pause & ~pause_q) toggles paused on the next edge.
- Paused freezes both the run tick and the adjust divider. Display keeps scanning.
- Dividers:
  - tick_cnt counts 0..TICK_DIV-1 and pulses tick on the wrap.
  - adj_cnt counts 0..ADJ_DIV-1 and pulses astep on the wrap.
  - Both hold while paused. Both clear to 0 on any change of the effective mode, so the first step after a mode change arrives a full period later.
- Run mode (00/11), on each tick:
  - sec<59: sec+1.
  - sec==59: sec=0 and min=min+1.
  - min==MIN_MOD-1 with sec==59: 00:00.
- Adjust up (01), on each astep:
  - Selected field +1, wrapping (sec 59→0, min MIN_MOD-1→0).
  - No carry into the other field. Run ticks are ignored.
- Adjust down (10), on each astep:
  - Selected field −1, wrapping (sec 0→59, min 0→MIN_MOD-1).
  - No borrow.
- sel change mid-adjust takes effect on the next astep; no divider clear.
- Display:
  - Digits: d3=min/10, d2=min%10, d1=sec/10, d0=sec%10.
  - scan index advances 0→1→2→3→0 every SCAN_DIV cycles.
  - anode asserts the single bit matching the scan index.
  - dp (bit7) is low only while digit 2 is active (the MM.SS separator).
- Segment codes (dp high):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Digits above 9 are unreachable.
- Reset mid-operation (any mode, paused or not) restores the full reset state on that edge.

Optional Feature:
- Macro: STOPWATCH_BLINK_EN.
- When defined: in adjust modes (01/10), the two digits of the selected field blink.
  - A toggle flips on every astep-period wrap; it keeps running while paused.
  - While the toggle is 1, those digits' anode bits are forced high (off).
  - The toggle resets to 0 and is held 0 in run mode.
- When undefined: no blink logic; adjust-mode display equals run-mode display.

Test Plan:
All scenarios use TICK_DIV=4, ADJ_DIV=2, SCAN_DIV=2, MIN_MOD=60.
1. Reset then run 40 cycles → 00:10 (sec=10, min=0); scan shows digit0=C0, digit1=F9, anode cycling 1110,1101,1011,0111; dp low only with anode 1011.
2. Preload via adjust to 59:58, then run 8 cycles → 00:00 wrap; single tick from 00:59 → 01:00.
3. adj=01, sel=1 from 00:58, 6 cycles → 00:01 (58→59→00→01), minutes unchanged. Then adj=10, sel=0 from min 0 → 59 after one astep.
4. Pulse pause high 3 cycles → paused; 40 further cycles, time unchanged. Second pause pulse → counting resumes; first tick exactly TICK_DIV cycles after the unpause edge. Pause held high generates only one toggle.
5. rst=1 for one cycle during adjust-down while paused → next cycle: 00:00, paused=0, anode=1111, seven_segment=FF; following cycle drives digit0=C0.
6. With STOPWATCH_BLINK_EN, adj=01, sel=0 → anode bits 3,2 suppressed on alternate astep periods, bits 1,0 always scanned. Without the macro → never suppressed.
